rob_dispatch_ctrl: RTL and testbench
====================================

# rob_dispatch_ctrl

Two-wide dispatch scheduler between the decode stage and the ROB/RS pair. Buffers one decoded group of up to two instructions, grants in-order dispatch slots limited by ROB occupancy (`STRUCTURE_FULL` status) and free RS slots, and drives the ROB's `dispatch_en_i`. It also sequences branch-recovery flushes and the halt stop, and keeps a stall counter for performance analysis.

## Interface
- `PKT_W`, default 64: width of one opaque dispatch packet (renamed instruction payload).
- `STALL_W`, default 16: width of the stall counter.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  2  decode group valid; legal values 00, 01, 11.
- `in_pkt_i`  in  2×PKT_W  decode packets; [0] is older.
- `in_halt_i`  in  2  packet is a halt instruction.
- `in_ready_o`  out  1  group accepted at this edge when `in_valid_i`≠00.
- `rob_full_i`  in  STRUCTURE_FULL  ROB status: FULL, ONE_LEFT, MORE_LEFT, ILLEGAL.
- `rs_avail_i`  in  2  free RS slots, saturated at 2 (value 3 treated as 2).
- `branch_recover_i`  in  1  mispredict recovery, same signal as the ROB's `branch_recover_i[0]`.
- `dispatch_en_o`  out  2  to ROB/RS; only 00, 01, 11 ever driven.
- `disp_pkt_o`  out  2×PKT_W  packets for the dispatched slots.
- `halted_o`  out  1  halt dispatched; no further dispatch.
- `stall_cnt_o`  out  STALL_W  saturating count of resource-stall cycles.

## Operation
- Buffer: two slots, `cnt` ∈ {0,1,2}; slot 0 is always the oldest.
- Capacity: `rob_cap` = 0 for FULL or ILLEGAL, 1 for ONE_LEFT, 2 for MORE_LEFT.
- Grant count: `n = min(rob_cap, rs_cap, cnt)`, where `rs_cap` = min(`rs_avail_i`, 2).
- Halt rule: if slot 0 is a halt, `n` is capped at 1.
- Dispatch outputs:
  - `dispatch_en_o` = 00 / 01 / 11 for n = 0 / 1 / 2.
  - `disp_pkt_o[k]` = slot k; contents are don't-care when the slot is not enabled.
- Buffer update:
  - Dispatched entries are removed.
  - If n=1 and cnt=2, slot 1 shifts to slot 0.
- Accept: `in_ready_o` = (state==RUN) && (cnt − n == 0).
  - On accept with 01, cnt becomes 1; with 11, cnt becomes 2.
  - `in_valid_i`=10 is ignored: not accepted, never buffered.
- States:
  - RUN: normal operation.
  - RUN → FLUSH when `branch_recover_i`=1.
  - RUN → HALT when a halt packet is dispatched (a halt in slot 1 of a 2-grant also triggers HALT).
  - FLUSH: exactly one cycle, then → RUN.
  - HALT: stays until reset.
- Recovery:
  - In the `branch_recover_i` cycle, `dispatch_en_o` is forced to 00 and `in_ready_o`=0.
  - The buffer is cleared at that edge (cnt=0).
  - FLUSH keeps both outputs at 0 for one more cycle while the ROB tail settles.
  - Recovery has priority over dispatch, accept and halt entry in the same cycle.
  - Recovery arriving in FLUSH restarts FLUSH for one more cycle.
  - Recovery in HALT is ignored.
- HALT: `dispatch_en_o`=00, `in_ready_o`=0, `halted_o`=1; buffer contents are frozen.
- Stall counter: increments when state==RUN && cnt>0 && n==0; saturates at all-ones and never wraps.

## Timing
- Reset (`reset`=0, asynchronous): state=RUN, cnt=0, slots zeroed, stall counter 0.
  - Outputs during reset: `dispatch_en_o`=00, `disp_pkt_o`=0, `in_ready_o`=1, `halted_o`=0, `stall_cnt_o`=0.
- Reset release: takes effect at the next rising edge; reset mid-HALT or mid-FLUSH returns to RUN.
- Combinational paths:
  - `dispatch_en_o`, `disp_pkt_o` and `in_ready_o` depend on registered buffer/state plus same-cycle `rob_full_i`, `rs_avail_i` and `branch_recover_i`.
  - This lets the ROB sample them at the same edge.
- Latency: a group accepted at edge E is presented for dispatch in cycle E+1. Minimum decode-to-ROB is one cycle.
- Throughput: two instructions per cycle sustained, with MORE_LEFT and `rs_avail_i`≥2.
- Partial grant: with n=1 and cnt=2, `in_ready_o`=0 that cycle and the next cycle presents the remaining entry.
- `halted_o` and `stall_cnt_o` are registered, updating one edge after the causing cycle.

## Test plan
- Reset, then 11 group with MORE_LEFT and `rs_avail_i`=2: accepted at edge 1; cycle 2 shows `dispatch_en_o`=11 with packets in order and `in_ready_o`=1.
- Group of 2 with ONE_LEFT: `dispatch_en_o`=01 and `in_ready_o`=0. Next cycle, MORE_LEFT: `dispatch_en_o`=01, the old slot 1 appears at `disp_pkt_o[0]`, and `in_ready_o`=1.
- FULL held for 5 cycles with cnt=2: `dispatch_en_o`=00, `stall_cnt_o` reaches 5; ILLEGAL behaves identically.
- `branch_recover_i` while cnt=2 and MORE_LEFT: `dispatch_en_o`=00 that cycle and the next (FLUSH); cnt=0; `in_ready_o` returns to 1 two cycles later.
- Halt in slot 0 with both slots valid and MORE_LEFT: `dispatch_en_o`=01; `halted_o`=1 next cycle; later valid inputs see `in_ready_o`=0 until `reset`=0.
- Stall counter preloaded near saturation (STALL_W=4) and stalled for 20 cycles: holds at 15; an async reset mid-stall clears it to 0 immediately.

Source files
------------

// File: rtl/rob_dispatch_ctrl_if.sv
// Decode-side and ROB/RS-side signal bundle for rob_dispatch_ctrl.
// The slave modport is the dispatch controller; master is the surrounding pipeline.
interface rob_dispatch_ctrl_if #(
  parameter int unsigned PKT_W = 64
);
  logic [1:0]            in_valid_i;
  logic [1:0][PKT_W-1:0] in_pkt_i;
  logic [1:0]            in_halt_i;
  logic                  in_ready_o;
  logic [1:0]            rob_full_i;
  logic [1:0]            rs_avail_i;
  logic [1:0]            dispatch_en_o;
  logic [1:0][PKT_W-1:0] disp_pkt_o;

  modport master (
    output in_valid_i, in_pkt_i, in_halt_i, rob_full_i, rs_avail_i,
    input  in_ready_o, dispatch_en_o, disp_pkt_o
  );

  modport slave (
    input  in_valid_i, in_pkt_i, in_halt_i, rob_full_i, rs_avail_i,
    output in_ready_o, dispatch_en_o, disp_pkt_o
  );
endinterface

// File: rtl/rob_dispatch_ctrl.sv
// Two-wide in-order dispatch scheduler: buffers one decode group, grants slots
// against ROB/RS capacity, sequences recovery flush and halt, counts resource stalls.
module rob_dispatch_ctrl #(
  parameter int unsigned PKT_W   = 64,
  parameter int unsigned STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rob_dispatch_ctrl_if.slave   bus,
  input  logic                 branch_recover_i,
  output logic                 halted_o,
  output logic [STALL_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0][PKT_W-1:0] slot_pkt_q, slot_pkt_d;
  logic [1:0]            slot_halt_q, slot_halt_d;

  logic [1:0] rob_cap, rs_cap, grant, n;
  logic       recover, accept, halt_disp, stall;

  // ROB status encoding: 00 FULL, 01 ONE_LEFT, 10 MORE_LEFT, 11 ILLEGAL.
  always_comb begin
    rob_cap = 2'd0;
    unique case (bus.rob_full_i)
      2'b01:   rob_cap = 2'd1;
      2'b10:   rob_cap = 2'd2;
      default: rob_cap = 2'd0;
    endcase
    rs_cap = (bus.rs_avail_i == 2'd3) ? 2'd2 : bus.rs_avail_i;

    grant = rob_cap;
    if (rs_cap < grant) grant = rs_cap;
    if (cnt_q < grant)  grant = cnt_q;
    if (slot_halt_q[0] && (grant > 2'd1)) grant = 2'd1;

    recover = branch_recover_i && (state_q != ST_HALT);
    n       = ((state_q == ST_RUN) && !branch_recover_i) ? grant : 2'd0;

    bus.dispatch_en_o = (n == 2'd2) ? 2'b11 : ((n == 2'd1) ? 2'b01 : 2'b00);
    bus.disp_pkt_o    = slot_pkt_q;
    bus.in_ready_o    = (state_q == ST_RUN) && !branch_recover_i && (cnt_q == n);

    accept    = bus.in_ready_o && bus.in_valid_i[0];
    halt_disp = ((n != 2'd0) && slot_halt_q[0]) || ((n == 2'd2) && slot_halt_q[1]);
    // Stall means resources withheld a grant, independent of recovery masking.
    stall     = (state_q == ST_RUN) && (cnt_q != 2'd0) && (grant == 2'd0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_pkt_d  = slot_pkt_q;
    slot_halt_d = slot_halt_q;
    unique case (state_q)
      ST_RUN: begin
        if (recover) begin
          state_d = ST_FLUSH;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - n;
          if ((n == 2'd1) && (cnt_q == 2'd2)) begin
            slot_pkt_d[0]  = slot_pkt_q[1];
            slot_halt_d[0] = slot_halt_q[1];
          end
          if (accept) begin
            slot_pkt_d  = bus.in_pkt_i;
            slot_halt_d = bus.in_halt_i;
            cnt_d       = bus.in_valid_i[1] ? 2'd2 : 2'd1;
          end
          if (halt_disp) state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        state_d = recover ? ST_FLUSH : ST_RUN;
        if (recover) cnt_d = 2'd0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      slot_pkt_q  <= '0;
      slot_halt_q <= '0;
      halted_o    <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_pkt_q  <= slot_pkt_d;
      slot_halt_q <= slot_halt_d;
      halted_o    <= (state_d == ST_HALT);
      if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Directed self-checking bench for rob_dispatch_ctrl (STALL_W reduced to 4).
module tb_rob_dispatch_ctrl;
  localparam int unsigned PKT_W   = 64;
  localparam int unsigned STALL_W = 4;
  localparam logic [1:0] FULL = 2'b00, ONE_LEFT = 2'b01, MORE_LEFT = 2'b10, ILLEGAL = 2'b11;

  logic               clk = 1'b0;
  logic               reset;
  logic               branch_recover_i;
  logic               halted_o;
  logic [STALL_W-1:0] stall_cnt_o;
  int vectors = 0;
  int miscompares = 0;

  rob_dispatch_ctrl_if #(.PKT_W(PKT_W)) bus ();

  rob_dispatch_ctrl #(.PKT_W(PKT_W), .STALL_W(STALL_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .branch_recover_i (branch_recover_i),
    .halted_o         (halted_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid_i   = 2'b00;
    bus.in_pkt_i     = '0;
    bus.in_halt_i    = 2'b00;
    bus.rob_full_i   = MORE_LEFT;
    bus.rs_avail_i   = 2'd2;
    branch_recover_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic load2(input logic [PKT_W-1:0] a, input logic [PKT_W-1:0] b, input logic [1:0] h);
    bus.in_valid_i  = 2'b11;
    bus.in_pkt_i[0] = a;
    bus.in_pkt_i[1] = b;
    bus.in_halt_i   = h;
    tick();
    bus.in_valid_i  = 2'b00;
    bus.in_halt_i   = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL rst_en: got %b want 00", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o !== '0) begin miscompares++; $display("FAIL rst_pkt: got %h want 0", bus.disp_pkt_o); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", bus.in_ready_o); end
    vectors++; if (halted_o !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted_o); end
    vectors++; if (stall_cnt_o !== 4'd0) begin miscompares++; $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_dispatch_pair();
    do_reset();
    bus.in_valid_i  = 2'b11;
    bus.in_pkt_i[0] = 64'hA0A0_0000_0000_000A;
    bus.in_pkt_i[1] = 64'hB0B0_0000_0000_000B;
    #2;
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL pair_ready0: got %b want 1", bus.in_ready_o); end
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL pair_en0: got %b want 00", bus.dispatch_en_o); end
    tick();
    bus.in_pkt_i[0] = 64'hC0C0_0000_0000_000C;
    bus.in_pkt_i[1] = 64'hD0D0_0000_0000_000D;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b11) begin miscompares++; $display("FAIL pair_en1: got %b want 11", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o[0] !== 64'hA0A0_0000_0000_000A) begin miscompares++; $display("FAIL pair_pkt0: got %h want A0A000000000000A", bus.disp_pkt_o[0]); end
    vectors++; if (bus.disp_pkt_o[1] !== 64'hB0B0_0000_0000_000B) begin miscompares++; $display("FAIL pair_pkt1: got %h want B0B000000000000B", bus.disp_pkt_o[1]); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL pair_ready1: got %b want 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 2'b00;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b11) begin miscompares++; $display("FAIL b2b_en: got %b want 11", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o[0] !== 64'hC0C0_0000_0000_000C) begin miscompares++; $display("FAIL b2b_pkt0: got %h want C0C000000000000C", bus.disp_pkt_o[0]); end
    vectors++; if (bus.disp_pkt_o[1] !== 64'hD0D0_0000_0000_000D) begin miscompares++; $display("FAIL b2b_pkt1: got %h want D0D000000000000D", bus.disp_pkt_o[1]); end
    tick();
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL pair_empty: got %b want 00", bus.dispatch_en_o); end
    bus.in_valid_i = 2'b10;
    tick();
    bus.in_valid_i = 2'b00;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL valid10_ignored: got %b want 00", bus.dispatch_en_o); end
  endtask

  task automatic test_partial();
    do_reset();
    load2(64'h0000_0000_0000_00E1, 64'h0000_0000_0000_00F2, 2'b00);
    bus.rob_full_i = ONE_LEFT;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b01) begin miscompares++; $display("FAIL part_en0: got %b want 01", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o[0] !== 64'h0000_0000_0000_00E1) begin miscompares++; $display("FAIL part_pkt0: got %h want E1", bus.disp_pkt_o[0]); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL part_ready0: got %b want 0", bus.in_ready_o); end
    tick();
    bus.rob_full_i = MORE_LEFT;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b01) begin miscompares++; $display("FAIL part_en1: got %b want 01", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o[0] !== 64'h0000_0000_0000_00F2) begin miscompares++; $display("FAIL part_shift: got %h want F2", bus.disp_pkt_o[0]); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL part_ready1: got %b want 1", bus.in_ready_o); end
    tick();
    // RS availability limits: 3 saturates to 2, 1 allows one, 0 blocks.
    load2(64'h11, 64'h22, 2'b00);
    bus.rs_avail_i = 2'd3;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b11) begin miscompares++; $display("FAIL rs3_en: got %b want 11", bus.dispatch_en_o); end
    tick();
    load2(64'h33, 64'h44, 2'b00);
    bus.rs_avail_i = 2'd1;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b01) begin miscompares++; $display("FAIL rs1_en: got %b want 01", bus.dispatch_en_o); end
    bus.rs_avail_i = 2'd0;
    #1;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL rs0_en: got %b want 00", bus.dispatch_en_o); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL rs0_ready: got %b want 0", bus.in_ready_o); end
  endtask

  task automatic test_stall(input logic [1:0] status);
    do_reset();
    load2(64'h55, 64'h66, 2'b00);
    bus.rob_full_i = status;
    for (int i = 0; i < 5; i++) begin
      #2;
      vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL stall_en[%0d] status %b: got %b want 00", i, status, bus.dispatch_en_o); end
      tick();
    end
    vectors++; if (stall_cnt_o !== 4'd5) begin miscompares++; $display("FAIL stall_cnt status %b: got %0d want 5", status, stall_cnt_o); end
  endtask

  task automatic test_recover();
    do_reset();
    load2(64'h77, 64'h88, 2'b00);
    branch_recover_i = 1'b1;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL rec_en0: got %b want 00", bus.dispatch_en_o); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL rec_ready0: got %b want 0", bus.in_ready_o); end
    tick();
    branch_recover_i = 1'b0;
    bus.in_valid_i   = 2'b11;
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL flush_en: got %b want 00", bus.dispatch_en_o); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 2'b00;
    #2;
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL rec_ready2: got %b want 1", bus.in_ready_o); end
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL rec_cleared: got %b want 00", bus.dispatch_en_o); end
    branch_recover_i = 1'b1;
    tick();
    tick();
    branch_recover_i = 1'b0;
    #2;
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reflush_ready: got %b want 0", bus.in_ready_o); end
    tick();
    #2;
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reflush_exit: got %b want 1", bus.in_ready_o); end
  endtask

  task automatic test_halt();
    do_reset();
    load2(64'h0000_0000_0000_0A17, 64'h0000_0000_0000_0B17, 2'b01);
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b01) begin miscompares++; $display("FAIL halt_en: got %b want 01", bus.dispatch_en_o); end
    vectors++; if (bus.disp_pkt_o[0] !== 64'h0000_0000_0000_0A17) begin miscompares++; $display("FAIL halt_pkt: got %h want A17", bus.disp_pkt_o[0]); end
    vectors++; if (halted_o !== 1'b0) begin miscompares++; $display("FAIL halt_early: got %b want 0", halted_o); end
    tick();
    bus.in_valid_i   = 2'b11;
    branch_recover_i = 1'b1;
    #2;
    vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halted: got %b want 1", halted_o); end
    vectors++; if (bus.in_ready_o !== 1'b0) begin miscompares++; $display("FAIL halt_ready: got %b want 0", bus.in_ready_o); end
    tick();
    branch_recover_i = 1'b0;
    #2;
    vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %b want 1", halted_o); end
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL halt_en_hold: got %b want 00", bus.dispatch_en_o); end
    reset = 1'b0;
    #1;
    vectors++; if (halted_o !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got %b want 0", halted_o); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL halt_reset_ready: got %b want 1", bus.in_ready_o); end
    do_reset();
    load2(64'h99, 64'hAA, 2'b10);
    #2;
    vectors++; if (bus.dispatch_en_o !== 2'b11) begin miscompares++; $display("FAIL halt1_en: got %b want 11", bus.dispatch_en_o); end
    tick();
    #2;
    vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL halt1_halted: got %b want 1", halted_o); end
  endtask

  task automatic test_saturate();
    do_reset();
    load2(64'hBB, 64'hCC, 2'b00);
    bus.rob_full_i = FULL;
    repeat (20) tick();
    #2;
    vectors++; if (stall_cnt_o !== 4'd15) begin miscompares++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt_o); end
    vectors++; if (bus.dispatch_en_o !== 2'b00) begin miscompares++; $display("FAIL sat_en: got %b want 00", bus.dispatch_en_o); end
    reset = 1'b0;
    #1;
    vectors++; if (stall_cnt_o !== 4'd0) begin miscompares++; $display("FAIL sat_reset: got %0d want 0", stall_cnt_o); end
    vectors++; if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL sat_reset_ready: got %b want 1", bus.in_ready_o); end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_dispatch_pair();
    test_partial();
    test_stall(FULL);
    test_stall(ILLEGAL);
    test_recover();
    test_halt();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
